// File: rtl/chacha_qr_seq.sv
// Sequencer that steps an external ChaCha ISE datapath through repeated quarter-rounds.
// Each quarter-round is four single-cycle ISE ops; the sequencer only routes words.
module chacha_qr_seq (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    input  logic [31:0] in_d,
    input  logic [3:0]  in_rounds,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_c,
    output logic [31:0] out_d,
    output logic [63:0] ise_rs1,
    output logic [63:0] ise_rs2,
    output logic        ise_op_ad0,
    output logic        ise_op_bc0,
    output logic        ise_op_ad1,
    output logic        ise_op_bc1,
    input  logic [63:0] ise_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] a_reg, b_reg, c_reg, d_reg;
    logic [31:0] a_next, b_next, c_next, d_next;
    logic [1:0]  s_reg, s_next;
    logic [3:0]  r_reg, r_next;
    logic [3:0]  op_sel;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_reg <= IDLE;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            c_reg     <= 32'd0;
            d_reg     <= 32'd0;
            s_reg     <= 2'd0;
            r_reg     <= 4'd0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            s_reg     <= s_next;
            r_reg     <= r_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        s_next     = s_reg;
        r_next     = r_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = in_a;
                    b_next     = in_b;
                    c_next     = in_c;
                    d_next     = in_d;
                    s_next     = 2'd0;
                    r_next     = in_rounds;
                    state_next = (in_rounds != 4'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                s_next = s_reg + 2'd1;
                // Even steps rewrite the {a,d} pair, odd steps the {b,c} pair.
                if (!s_reg[0]) begin
                    a_next = ise_rd[63:32];
                    d_next = ise_rd[31:0];
                end else begin
                    b_next = ise_rd[63:32];
                    c_next = ise_rd[31:0];
                end
                if (s_reg == 2'd3) begin
                    r_next = r_reg - 4'd1;
                    if (r_reg == 4'd1) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_op_sel
            assign op_sel[gi] = (state_reg == RUN) && (s_reg == 2'(gi));
        end
    endgenerate

    assign ise_op_ad0 = op_sel[0];
    assign ise_op_bc0 = op_sel[1];
    assign ise_op_ad1 = op_sel[2];
    assign ise_op_bc1 = op_sel[3];

    assign in_ready  = (state_reg == IDLE) && !g_reset;
    assign out_valid = (state_reg == DONE);
    assign out_a     = a_reg;
    assign out_b     = b_reg;
    assign out_c     = c_reg;
    assign out_d     = d_reg;
    assign ise_rs1   = {a_reg, d_reg};
    assign ise_rs2   = {b_reg, c_reg};

endmodule

// File: tb/tb_chacha_qr_seq.sv
// Directed bench for chacha_qr_seq with a behavioural ChaCha ISE datapath on ise_rd.
module tb_chacha_qr_seq;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic [3:0]  in_rounds = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a, out_b, out_c, out_d;
    logic [63:0] ise_rs1, ise_rs2, ise_rd;
    logic        ise_op_ad0, ise_op_bc0, ise_op_ad1, ise_op_bc1;
    logic [3:0]  ops;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [31:0] RA = 32'h11111111, RB = 32'h01020304;
    localparam logic [31:0] RC = 32'h9b8d6f43, RD = 32'h01234567;
    localparam logic [127:0] R1_EXP = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};

    chacha_qr_seq dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_rounds(in_rounds),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .ise_rs1(ise_rs1), .ise_rs2(ise_rs2),
        .ise_op_ad0(ise_op_ad0), .ise_op_bc0(ise_op_bc0),
        .ise_op_ad1(ise_op_ad1), .ise_op_bc1(ise_op_bc1),
        .ise_rd(ise_rd)
    );

    always #5 g_clk = ~g_clk;

    assign ops = {ise_op_bc1, ise_op_ad1, ise_op_bc0, ise_op_ad0};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference ISE datapath: one half-step of the quarter-round per op.
    function automatic logic [63:0] ise_model(input logic [63:0] rs1, input logic [63:0] rs2,
                                              input logic [3:0] op);
        logic [31:0] a, b, c, d, na, nb, nc, nd;
        a = rs1[63:32]; d = rs1[31:0]; b = rs2[63:32]; c = rs2[31:0];
        case (op)
            4'b0001: begin na = a + b; nd = rotl(d ^ na, 16); return {na, nd}; end
            4'b0010: begin nc = c + d; nb = rotl(b ^ nc, 12); return {nb, nc}; end
            4'b0100: begin na = a + b; nd = rotl(d ^ na, 8);  return {na, nd}; end
            4'b1000: begin nc = c + d; nb = rotl(b ^ nc, 7);  return {nb, nc}; end
            default: return 64'd0;
        endcase
    endfunction

    always_comb ise_rd = ise_model(ise_rs1, ise_rs2, ops);

    function automatic logic [127:0] qr(input logic [127:0] v);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = v;
        a = a + b; d = d ^ a; d = rotl(d, 16);
        c = c + d; b = b ^ c; b = rotl(b, 12);
        a = a + b; d = d ^ a; d = rotl(d, 8);
        c = c + d; b = b ^ c; b = rotl(b, 7);
        return {a, b, c, d};
    endfunction

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic start_job(input logic [127:0] v, input logic [3:0] rounds);
        {in_a, in_b, in_c, in_d} = v;
        in_rounds = rounds;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns cycles after accept at which out_valid was first seen (1 = right after accept).
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        g_reset = 1'b1;
        tick(); tick();
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        else pass_cnt++;
        g_reset = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, ops} !== 6'b100000)
            $display("FAIL reset_ctrl got=%b exp=100000", {in_ready, out_valid, ops});
        else pass_cnt++;
        total_cnt++;
        if ({out_a, out_b, out_c, out_d, ise_rs1, ise_rs2} !== 256'd0)
            $display("FAIL reset_data got=%h exp=0", {out_a, out_b, out_c, out_d});
        else pass_cnt++;
        $display("reset done");
    endtask

    task automatic test_rfc_r1();
        int cyc;
        out_ready = 1'b1;
        start_job({RA, RB, RC, RD}, 4'd1);
        wait_done(cyc);
        total_cnt++;
        if (cyc !== 5) $display("FAIL r1_latency got=%0d exp=5", cyc);
        else pass_cnt++;
        total_cnt++;
        if ({out_a, out_b, out_c, out_d} !== R1_EXP)
            $display("FAIL r1_result got=%h exp=%h", {out_a, out_b, out_c, out_d}, R1_EXP);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL r1_idle got=%b exp=10", {in_ready, out_valid});
        else pass_cnt++;
        $display("job rounds=1 result=%h latency=%0d", {out_a, out_b, out_c, out_d}, cyc);
    endtask

    task automatic test_zero_rounds();
        logic [127:0] v = {32'hdeadbeef, 32'h0badf00d, 32'h12345678, 32'hcafebabe};
        out_ready = 1'b0;
        start_job(v, 4'd0);
        total_cnt++;
        if ({out_valid, in_ready, ops} !== 6'b100000)
            $display("FAIL r0_ctrl got=%b exp=100000", {out_valid, in_ready, ops});
        else pass_cnt++;
        total_cnt++;
        if ({out_a, out_b, out_c, out_d} !== v)
            $display("FAIL r0_result got=%h exp=%h", {out_a, out_b, out_c, out_d}, v);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if ({in_ready, out_valid, ops} !== 6'b100000)
            $display("FAIL r0_idle got=%b exp=100000", {in_ready, out_valid, ops});
        else pass_cnt++;
        $display("job rounds=0 result=%h", v);
    endtask

    task automatic test_rounds2();
        logic [127:0] exp_v = qr(qr({RA, RB, RC, RD}));
        logic [3:0]   exp_op;
        out_ready = 1'b0;
        start_job({RA, RB, RC, RD}, 4'd2);
        for (int i = 1; i <= 8; i++) begin
            exp_op = 4'b0001 << ((i - 1) % 4);
            total_cnt++;
            if ({ops, in_ready, out_valid} !== {exp_op, 2'b00})
                $display("FAIL r2_step%0d got=%b exp=%b", i, {ops, in_ready, out_valid}, {exp_op, 2'b00});
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({ops, in_ready, out_valid} !== 6'b000001)
            $display("FAIL r2_done got=%b exp=000001", {ops, in_ready, out_valid});
        else pass_cnt++;
        total_cnt++;
        if ({out_a, out_b, out_c, out_d} !== exp_v)
            $display("FAIL r2_result got=%h exp=%h", {out_a, out_b, out_c, out_d}, exp_v);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        $display("job rounds=2 result=%h", exp_v);
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        start_job({RA, RB, RC, RD}, 4'd1);
        wait_done(cyc);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({out_valid, in_ready, out_a, out_b, out_c, out_d} !== {2'b10, R1_EXP})
                $display("FAIL bp_hold%0d got=%b/%h exp=10/%h", i, {out_valid, in_ready},
                         {out_a, out_b, out_c, out_d}, R1_EXP);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid});
        else pass_cnt++;
        $display("job rounds=1 backpressure result=%h", R1_EXP);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        out_ready = 1'b1;
        start_job({RA, RB, RC, RD}, 4'd3);
        tick(); tick();
        total_cnt++;
        if (ops !== 4'b0100) $display("FAIL mid_step2 got=%b exp=0100", ops);
        else pass_cnt++;
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, in_ready, ops, ise_rs1, ise_rs2} !== {2'b01, 4'b0000, 128'd0})
            $display("FAIL mid_reset got=%b/%h exp=010000/0", {out_valid, in_ready, ops}, {ise_rs1, ise_rs2});
        else pass_cnt++;
        start_job({RA, RB, RC, RD}, 4'd1);
        wait_done(cyc);
        total_cnt++;
        if ({cyc[3:0], out_a, out_b, out_c, out_d} !== {4'd5, R1_EXP})
            $display("FAIL mid_next got=%0d/%h exp=5/%h", cyc, {out_a, out_b, out_c, out_d}, R1_EXP);
        else pass_cnt++;
        tick();
        $display("job rounds=3 discarded by reset; follow-up result=%h", R1_EXP);
    endtask

    task automatic test_back_to_back();
        int accepts = 0, dones = 0, overlap = 0, bad_res = 0;
        int acc_cyc[$];
        out_ready = 1'b1;
        {in_a, in_b, in_c, in_d} = {RA, RB, RC, RD};
        in_rounds = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (in_ready && out_valid) overlap++;
            if (in_valid && in_ready) begin
                accepts++;
                acc_cyc.push_back(i);
            end
            if (out_valid && out_ready) begin
                dones++;
                if ({out_a, out_b, out_c, out_d} !== R1_EXP) bad_res++;
                $display("job b2b done at cycle %0d result=%h", i, {out_a, out_b, out_c, out_d});
            end
            tick();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (accepts !== 3) $display("FAIL b2b_accepts got=%0d exp=3", accepts);
        else pass_cnt++;
        total_cnt++;
        if (dones !== 3) $display("FAIL b2b_dones got=%0d exp=3", dones);
        else pass_cnt++;
        total_cnt++;
        if (acc_cyc.size() < 2 || acc_cyc[1] !== 6)
            $display("FAIL b2b_second_accept got=%0d exp=6", acc_cyc.size() < 2 ? -1 : acc_cyc[1]);
        else pass_cnt++;
        total_cnt++;
        if ({overlap, bad_res} !== 64'd0)
            $display("FAIL b2b_integrity got=overlap %0d bad %0d exp=0 0", overlap, bad_res);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_rfc_r1();
        test_zero_rounds();
        test_rounds2();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/chacha_qr_seq.md
CHACHA_QR_SEQ -- requirements
Module: chacha_qr_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: g_clk and g_reset.
REQ-002 Ports (name, direction, width, meaning), one per line:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_reset  in  1  synchronous active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  sequencer can accept a job.
- in_a, in_b, in_c, in_d  in  32 each  quarter-round input words.
- in_rounds  in  4  number of successive quarter-rounds to apply, 0..15.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_a, out_b, out_c, out_d  out  32 each  result words.
- ise_rs1  out  64  {a,d} operand to the ChaCha ISE datapath.
- ise_rs2  out  64  {b,c} operand to the ChaCha ISE datapath.
- ise_op_ad0, ise_op_bc0, ise_op_ad1, ise_op_bc1  out  1 each  ISE op selects.
- ise_rd  in  64  combinational ISE result for the current operands and op.

REQ-003 SHALL have no parameters.

Function
REQ-004 SHALL hold state registers A, B, C, D (32b), step counter S (2b), round counter R (4b) and FSM state in {IDLE, RUN, DONE}.
REQ-005 in_ready SHALL be 1 iff state==IDLE and g_reset==0.
REQ-006 The accept edge is a rising edge with in_valid&&in_ready; on it the block SHALL load A..D from in_a..in_d, set R=in_rounds and S=0, and go to RUN if in_rounds!=0, else to DONE.
REQ-007 ise_rs1 SHALL equal {A,D} and ise_rs2 SHALL equal {B,C} at all times.
REQ-008 In RUN exactly one op select SHALL be high, by S:
- S=0: ad0
- S=1: bc0
- S=2: ad1
- S=3: bc1
REQ-009 Outside RUN all four op selects SHALL be 0.
REQ-010 On each RUN edge with S=0 or S=2, the block SHALL load {A,D} from ise_rd[63:32], ise_rd[31:0].
REQ-011 On each RUN edge with S=1 or S=3, the block SHALL load {B,C} from ise_rd[63:32], ise_rd[31:0].
REQ-012 S SHALL increment modulo 4 on every RUN edge.
REQ-013 On a RUN edge with S=3, R SHALL decrement; if R was 1, state SHALL go to DONE, else remain in RUN with S wrapping to 0.
REQ-014 out_valid SHALL be 1 iff state==DONE; out_a..out_d SHALL equal A..D.
REQ-015 In DONE, A..D SHALL hold until the handshake edge.
REQ-016 On an edge with out_valid&&out_ready the block SHALL go to IDLE.
REQ-017 Result latency: out_valid SHALL first be high in the cycle 4*in_rounds+1 cycles after the accept edge, i.e. 1 cycle for in_rounds=0 and 61 cycles for in_rounds=15.
REQ-018 in_valid SHALL be ignored in RUN and DONE.
REQ-019 in_ready and out_valid SHALL never both be 1; back-to-back jobs therefore incur at least one IDLE cycle.
REQ-020 The block SHALL hold no combinational path from in_valid or out_ready to any output other than through registers, except the in_ready dependency on g_reset.
REQ-021 Arithmetic SHALL be performed only by the external ISE datapath; the sequencer SHALL perform no arithmetic on A..D.

Reset
REQ-022 While g_reset is high at an edge, the block SHALL set state=IDLE, A=B=C=D=0, S=0 and R=0, regardless of the current state, including mid-RUN and DONE.
REQ-023 After that reset edge the outputs SHALL be: out_valid=0, all op selects 0, ise_rs1=ise_rs2=0, out_a..out_d=0.
REQ-024 An in-flight job SHALL be discarded by reset and never produce out_valid.

Verification
REQ-025 The bench SHALL drive ise_rd from a reference ChaCha ISE datapath model and SHALL cover these directed scenarios:
- RFC 7539 s2.1.1 vector, in_rounds=1, out_ready=1: a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> out_valid high 5 cycles after accept with a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb.
- in_rounds=0, any words -> out_valid 1 cycle after accept; outputs equal inputs; op selects stay 0 throughout.
- in_rounds=2, RFC vector -> op sequence ad0,bc0,ad1,bc1,ad0,bc0,ad1,bc1 on consecutive cycles; result equals two model quarter-rounds; in_ready=0 for cycles 1..9 after accept.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid and out_a..d stable; IDLE and in_ready=1 one cycle after out_ready rises.
- Reset mid-RUN (S=2) -> next cycle out_valid=0, in_ready=1, ops=0, ise_rs1=ise_rs2=0; the next job then completes correctly.
- in_valid held high through a whole job -> exactly one accept per IDLE visit; second job accepted only after the DONE handshake.
